// File: rtl/pipe_field_pkg.sv
// Shared definitions for the scrolling pipe field: slot layout, LFSR polynomial
// and the per-step movement kinds.
package pipe_field_pkg;

  localparam int unsigned SLOT_W  = 24;
  localparam int unsigned FIELD_W = 8;
  localparam int unsigned POS_LSB = 16;
  localparam int unsigned MAX_LSB = 8;
  localparam int unsigned MIN_LSB = 0;

  // Galois right-shift form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_POLY = 16'hB400;

  typedef enum logic [1:0] {
    MV_HOLD,
    MV_SHIFT,
    MV_RECYCLE
  } move_e;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ LFSR_POLY;
    return r;
  endfunction

endpackage

// File: rtl/pipe_lfsr.sv
// 16-bit Galois LFSR used for gap placement; load wins over advance.
module pipe_lfsr
  import pipe_field_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        load_i,
  input  logic        adv_i,
  output logic [15:0] state_o
);

  logic [15:0] state_q;

  always_ff @(posedge clk) begin
    if (load_i) begin
      state_q <= SEED;
    end else if (adv_i) begin
      state_q <= lfsr_next(state_q);
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/pipe_field.sv
// Scrolling pipe field: slot positions and gaps, scroll divider with speed-up,
// score counting and registered collision detection.
module pipe_field
  import pipe_field_pkg::*;
#(
  parameter int unsigned N_PIPE       = 3,
  parameter int unsigned GAP_LEN      = 8,
  parameter int unsigned PIPE_SPACING = 50,
  parameter int unsigned SCROLL_DIV   = 3,
  parameter int unsigned LEVEL_STEP   = 5,
  parameter int unsigned BIRD_COL     = 10,
  parameter int unsigned HIT_LEFT     = 6,
  parameter int unsigned HIT_RIGHT    = 2,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [7:0]                 n_row,
  input  logic [7:0]                 bird_alt,
  output logic [SLOT_W*N_PIPE-1:0]   pipes,
  output logic                       hit,
  output logic [15:0]                score,
  output logic                       score_pulse,
  output logic [3:0]                 div_cur
);

  localparam logic [7:0]  GAP8     = 8'(GAP_LEN);
  localparam logic [7:0]  WIN_LO   = (HIT_LEFT > BIRD_COL) ? 8'd0 : 8'(BIRD_COL - HIT_LEFT);
  localparam logic [7:0]  WIN_HI   = (BIRD_COL + HIT_RIGHT > 255) ? 8'd255
                                                                  : 8'(BIRD_COL + HIT_RIGHT);
  localparam logic [8:0]  SPACE9   = 9'(PIPE_SPACING);
  localparam logic [3:0]  DIV_INIT = 4'(SCROLL_DIV);
  localparam logic [15:0] LVL_LAST = (LEVEL_STEP == 0) ? 16'd0 : 16'(LEVEL_STEP - 1);

  logic [7:0]  pos_q [N_PIPE];
  logic [7:0]  pos_d [N_PIPE];
  logic [7:0]  min_q [N_PIPE];
  logic [7:0]  min_d [N_PIPE];
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  div_q, div_d;
  logic [15:0] score_q, score_d;
  logic [15:0] lvl_q, lvl_d;
  logic        pulse_q, pulse_d;
  logic        hit_q, hit_d;

  logic [15:0] lfsr_q;
  logic        lfsr_adv;

  logic        room;
  logic [7:0]  span;
  logic [7:0]  rst_min;
  logic [15:0] rec_mod;
  logic [7:0]  rec_min;
  logic [8:0]  tail_sum;
  logic [7:0]  max0;
  logic        step;
  logic        in_win;
  move_e       move;

  pipe_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .load_i  (rst),
    .adv_i   (lfsr_adv),
    .state_o (lfsr_q)
  );

  // Gap placement depends on the live playfield height
  always_comb begin
    room     = n_row > GAP8;
    span     = n_row - GAP8;
    rst_min  = room ? (span >> 1) : '0;
    rec_mod  = lfsr_q % {8'd0, (room ? span : 8'd1)};
    rec_min  = room ? rec_mod[7:0] : '0;
    tail_sum = {1'b0, pos_q[N_PIPE-1]} + SPACE9;
    max0     = min_q[0] + GAP8;
    in_win   = (pos_q[0] >= WIN_LO) && (pos_q[0] <= WIN_HI);
    step     = en && (cnt_q == div_q - 4'd1);
    if (!step)               move = MV_HOLD;
    else if (pos_q[0] == '0) move = MV_RECYCLE;
    else                     move = MV_SHIFT;
  end

  always_comb begin
    pos_d    = pos_q;
    min_d    = min_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    score_d  = score_q;
    lvl_d    = lvl_q;
    pulse_d  = 1'b0;
    hit_d    = 1'b0;
    lfsr_adv = 1'b0;

    if (en) begin
      hit_d = in_win && ((bird_alt <= min_q[0]) || (bird_alt >= max0));

      if (step) begin
        cnt_d = '0;
      end else if (cnt_q >= div_q) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end

      // Score is judged on the pre-step leading position, before any shift
      if (step && (pos_q[0] == WIN_LO) && (score_q != '1)) begin
        score_d = score_q + 16'd1;
        pulse_d = 1'b1;
        if (LEVEL_STEP != 0) begin
          if (lvl_q == LVL_LAST) begin
            lvl_d = '0;
            if (div_q > 4'd1) div_d = div_q - 4'd1;
          end else begin
            lvl_d = lvl_q + 16'd1;
          end
        end
      end
    end

    case (move)
      MV_SHIFT: begin
        for (int unsigned i = 0; i < N_PIPE; i++) begin
          pos_d[i] = pos_q[i] - 8'd1;
        end
      end
      MV_RECYCLE: begin
        for (int unsigned i = 0; i < N_PIPE - 1; i++) begin
          pos_d[i] = pos_q[i+1];
          min_d[i] = min_q[i+1];
        end
        pos_d[N_PIPE-1] = tail_sum[8] ? 8'hFF : tail_sum[7:0];
        min_d[N_PIPE-1] = rec_min;
        lfsr_adv        = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_PIPE; i++) begin
        pos_q[i] <= 8'(PIPE_SPACING * (i + 1));
        min_q[i] <= rst_min;
      end
      cnt_q   <= '0;
      div_q   <= DIV_INIT;
      score_q <= '0;
      lvl_q   <= '0;
      pulse_q <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      pos_q   <= pos_d;
      min_q   <= min_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      score_q <= score_d;
      lvl_q   <= lvl_d;
      pulse_q <= pulse_d;
      hit_q   <= hit_d;
    end
  end

  always_comb begin
    pipes = '0;
    for (int unsigned i = 0; i < N_PIPE; i++) begin
      pipes[SLOT_W*i + POS_LSB +: FIELD_W] = pos_q[i];
      pipes[SLOT_W*i + MAX_LSB +: FIELD_W] = min_q[i] + GAP8;
      pipes[SLOT_W*i + MIN_LSB +: FIELD_W] = min_q[i];
    end
  end

  assign hit         = hit_q;
  assign score       = score_q;
  assign score_pulse = pulse_q;
  assign div_cur     = div_q;

endmodule

// File: tb/tb_pipe_field.sv
// Self-checking bench for pipe_field: a cycle model feeds an expected-output
// queue each clock, and predicted score increments feed a score scoreboard.
module tb_pipe_field;

  localparam int NP = 3, GAP = 8, SP = 50, SDIV = 3, LSTEP = 5;
  localparam int BC = 10, HL = 6, HR = 2;
  localparam int SEED = 'hACE1;
  localparam logic [71:0] RST_PIPES40 = {8'd150, 8'd24, 8'd16, 8'd100, 8'd24, 8'd16,
                                         8'd50, 8'd24, 8'd16};
  localparam logic [71:0] RST_PIPES6  = {8'd150, 8'd8, 8'd0, 8'd100, 8'd8, 8'd0,
                                         8'd50, 8'd8, 8'd0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [7:0]  n_row = 8'd40;
  logic [7:0]  bird_alt = 8'd20;
  logic [71:0] pipes;
  logic        hit;
  logic [15:0] score;
  logic        score_pulse;
  logic [3:0]  div_cur;
  logic [93:0] obs;

  int checks = 0;
  int errors = 0;

  logic [93:0] exp_q[$];
  int          sb_score[$];

  int m_pos[NP];
  int m_min[NP];
  int m_cnt, m_div, m_score, m_lfsr;
  bit m_hit, m_pulse;

  always #5 clk = ~clk;

  pipe_field #(
    .N_PIPE(NP), .GAP_LEN(GAP), .PIPE_SPACING(SP), .SCROLL_DIV(SDIV),
    .LEVEL_STEP(LSTEP), .BIRD_COL(BC), .HIT_LEFT(HL), .HIT_RIGHT(HR),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .n_row(n_row), .bird_alt(bird_alt),
    .pipes(pipes), .hit(hit), .score(score), .score_pulse(score_pulse),
    .div_cur(div_cur)
  );

  assign obs = {pipes, hit, score, score_pulse, div_cur};

  function automatic int lfsr_step(int s);
    int r;
    r = s >> 1;
    if ((s & 1) != 0) r = r ^ 'hB400;
    return r;
  endfunction

  function automatic logic [93:0] model_snap();
    logic [71:0] p;
    for (int i = 0; i < NP; i++) begin
      p[24*i +: 24] = {8'(m_pos[i]), 8'(m_min[i] + GAP), 8'(m_min[i])};
    end
    return {p, m_hit, 16'(m_score), m_pulse, 4'(m_div)};
  endfunction

  function automatic void model_update();
    int lo, hi, last;
    lo = (HL > BC) ? 0 : BC - HL;
    hi = BC + HR;
    if (rst) begin
      for (int i = 0; i < NP; i++) begin
        m_pos[i] = SP * (i + 1);
        m_min[i] = (n_row > GAP) ? (int'(n_row) - GAP) / 2 : 0;
      end
      m_lfsr = SEED; m_cnt = 0; m_div = SDIV; m_score = 0;
      m_pulse = 0; m_hit = 0;
      sb_score.delete();
    end else if (!en) begin
      m_hit = 0; m_pulse = 0;
    end else begin
      m_hit = (m_pos[0] >= lo && m_pos[0] <= hi) &&
              (int'(bird_alt) <= m_min[0] || int'(bird_alt) >= (m_min[0] + GAP) % 256);
      m_pulse = 0;
      if (m_cnt == m_div - 1) begin
        m_cnt = 0;
        if (m_pos[0] == lo && m_score < 65535) begin
          m_score++;
          m_pulse = 1;
          sb_score.push_back(m_score);
          if (LSTEP != 0 && m_score % LSTEP == 0 && m_div > 1) m_div--;
        end
        if (m_pos[0] == 0) begin
          last = m_pos[NP-1] + SP;
          for (int i = 0; i < NP - 1; i++) begin
            m_pos[i] = m_pos[i+1];
            m_min[i] = m_min[i+1];
          end
          m_pos[NP-1] = (last > 255) ? 255 : last;
          m_min[NP-1] = (n_row > GAP) ? m_lfsr % (int'(n_row) - GAP) : 0;
          m_lfsr = lfsr_step(m_lfsr);
        end else begin
          for (int i = 0; i < NP; i++) m_pos[i]--;
        end
      end else begin
        m_cnt++;
      end
    end
  endfunction

  task automatic tick();
    exp_q.delete();
    @(posedge clk);
    model_update();
    exp_q.push_back(model_snap());
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [93:0] e;
    rst = 1'b1; en = 1'b0; n_row = 8'd40; bird_alt = 8'd20;
    tick();
    tick();
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_model got %h want %h", obs, e); end
    checks++;
    if (pipes !== RST_PIPES40) begin errors++; $display("FAIL reset_pipes got %h want %h", pipes, RST_PIPES40); end
    checks++;
    if ({hit, score, score_pulse, div_cur} !== {1'b0, 16'd0, 1'b0, 4'd3}) begin
      errors++; $display("FAIL reset_status got %h/%0d/%b/%0d want 0/0/0/3", hit, score, score_pulse, div_cur);
    end
  endtask

  task automatic test_scroll();
    logic [93:0] e;
    int want0, want2;
    rst = 1'b0; en = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL scroll_model got %h want %h", obs, e); end
      want0 = (c < 3) ? 50 : 49;
      want2 = (c < 3) ? 150 : 149;
      checks++;
      if (pipes[23:16] !== 8'(want0) || pipes[71:64] !== 8'(want2)) begin
        errors++; $display("FAIL scroll_pos clk%0d got %0d,%0d want %0d,%0d",
                           c, pipes[23:16], pipes[71:64], want0, want2);
      end
    end
  endtask

  task automatic test_recycle();
    logic [93:0] e;
    int want_min, next_min, n;
    for (int pass = 0; pass < 2; pass++) begin
      n = 0;
      while (!(m_pos[0] == 0 && m_cnt == m_div - 1) && n < 400) begin
        tick(); n++;
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL recycle_model got %h want %h", obs, e); end
      end
      checks++;
      if (n >= 400) begin errors++; $display("FAIL recycle_timeout got %0d cycles want <400", n); end
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL recycle_step got %h want %h", obs, e); end
      if (pass == 0) begin
        want_min = SEED % (40 - GAP);
        checks++;
        if ({pipes[71:64], pipes[47:40], pipes[23:16]} !== {8'd150, 8'd100, 8'd50}) begin
          errors++; $display("FAIL recycle_pos got %0d,%0d,%0d want 150,100,50",
                             pipes[71:64], pipes[47:40], pipes[23:16]);
        end
        checks++;
        if (pipes[55:48] !== 8'(want_min) || pipes[7:0] !== 8'd16) begin
          errors++; $display("FAIL recycle_min got %0d,%0d want %0d,16", pipes[55:48], pipes[7:0], want_min);
        end
        checks++;
        if (score !== 16'd1) begin errors++; $display("FAIL recycle_score got %0d want 1", score); end
      end else begin
        next_min = lfsr_step(SEED) % (40 - GAP);
        checks++;
        if (pipes[55:48] !== 8'(next_min)) begin
          errors++; $display("FAIL lfsr_once got %0d want %0d", pipes[55:48], next_min);
        end
      end
    end
  endtask

  task automatic test_hit();
    logic [93:0] e;
    int n;
    rst = 1'b1; en = 1'b0; n_row = 8'd38; bird_alt = 8'd19;
    tick();
    rst = 1'b0; en = 1'b1;
    n = 0;
    while (m_pos[0] != 10 && n < 300) begin
      tick(); n++;
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL hit_model got %h want %h", obs, e); end
    end
    checks++;
    if (pipes[7:0] !== 8'd15 || pipes[23:16] !== 8'd10) begin
      errors++; $display("FAIL hit_setup got pos %0d min %0d want 10,15", pipes[23:16], pipes[7:0]);
    end
    bird_alt = 8'd15; tick();
    checks++;
    if (hit !== 1'b1) begin errors++; $display("FAIL hit_on_min got %b want 1", hit); end
    bird_alt = 8'd16; tick();
    checks++;
    if (hit !== 1'b0) begin errors++; $display("FAIL hit_in_gap got %b want 0", hit); end
    bird_alt = 8'd23; tick();
    checks++;
    if (hit !== 1'b1) begin errors++; $display("FAIL hit_on_max got %b want 1", hit); end
    bird_alt = 8'd19;
    n = 0;
    while (m_pos[0] != 3 && n < 300) begin
      tick(); n++;
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL hit_model got %h want %h", obs, e); end
    end
    bird_alt = 8'd15; tick();
    checks++;
    if (hit !== 1'b0) begin errors++; $display("FAIL hit_outside got %b want 0", hit); end
  endtask

  task automatic test_speedup();
    logic [93:0] e;
    int n, pulses, want;
    bit prev;
    rst = 1'b1; en = 1'b0; n_row = 8'd40; bird_alt = 8'd20;
    tick();
    rst = 1'b0; en = 1'b1;
    n = 0; pulses = 0; prev = 1'b0;
    while (m_score < 15 && n < 6000) begin
      tick(); n++;
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL speed_model got %h want %h", obs, e); end
      if (score_pulse) begin
        pulses++;
        checks++;
        if (sb_score.size() == 0) begin
          errors++; $display("FAIL speed_pulse got unexpected pulse at score %0d want none", score);
        end else begin
          want = sb_score.pop_front();
          if (score !== 16'(want)) begin errors++; $display("FAIL speed_score got %0d want %0d", score, want); end
        end
        checks++;
        if (prev) begin errors++; $display("FAIL pulse_width got 2+ cycles want 1"); end
        if (pulses == 5) begin
          checks++;
          if (div_cur !== 4'd2) begin errors++; $display("FAIL speed_div5 got %0d want 2", div_cur); end
        end
      end
      prev = score_pulse;
    end
    checks++;
    if (pulses != 15 || score !== 16'd15) begin
      errors++; $display("FAIL speed_count got %0d pulses score %0d want 15", pulses, score);
    end
    for (int c = 0; c < 200; c++) begin
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL speed_model got %h want %h", obs, e); end
    end
    checks++;
    if (div_cur !== 4'd1) begin errors++; $display("FAIL speed_floor got %0d want 1", div_cur); end
  endtask

  task automatic test_enable_freeze();
    logic [93:0] e;
    int n;
    rst = 1'b1; en = 1'b0; n_row = 8'd40; bird_alt = 8'd0;
    tick();
    rst = 1'b0; en = 1'b1;
    n = 0;
    while (!(m_pos[0] == 8 && m_cnt == 1) && n < 300) begin
      tick(); n++;
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL freeze_model got %h want %h", obs, e); end
    end
    checks++;
    if (hit !== 1'b1) begin errors++; $display("FAIL freeze_prehit got %b want 1", hit); end
    en = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e || hit !== 1'b0 || pipes[23:16] !== 8'd8 || score !== 16'd0) begin
        errors++; $display("FAIL freeze_hold got %h want %h (pos 8, hit 0)", obs, e);
      end
    end
    en = 1'b1;
    tick();
    checks++;
    if (pipes[23:16] !== 8'd8 || hit !== 1'b1) begin
      errors++; $display("FAIL freeze_resume1 got pos %0d hit %b want 8,1", pipes[23:16], hit);
    end
    tick();
    checks++;
    if (pipes[23:16] !== 8'd7) begin errors++; $display("FAIL freeze_resume2 got %0d want 7", pipes[23:16]); end
  endtask

  task automatic test_reset_on_recycle();
    logic [93:0] e;
    int n;
    rst = 1'b1; en = 1'b0; n_row = 8'd40; bird_alt = 8'd20;
    tick();
    rst = 1'b0; en = 1'b1;
    n = 0;
    while (!(m_pos[0] == 0 && m_cnt == m_div - 1) && n < 400) begin
      tick(); n++;
    end
    rst = 1'b1;
    tick();
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL rstrec_model got %h want %h", obs, e); end
    checks++;
    if ({pipes, hit, score, score_pulse, div_cur} !== {RST_PIPES40, 1'b0, 16'd0, 1'b0, 4'd3}) begin
      errors++; $display("FAIL rstrec_values got %h want %h", obs, {RST_PIPES40, 1'b0, 16'd0, 1'b0, 4'd3});
    end
    n_row = 8'd6;
    tick();
    checks++;
    if (pipes !== RST_PIPES6) begin errors++; $display("FAIL small_row_rst got %h want %h", pipes, RST_PIPES6); end
    rst = 1'b0;
    n = 0;
    while (!(m_pos[0] == 0 && m_cnt == m_div - 1) && n < 400) begin
      tick(); n++;
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL small_row_model got %h want %h", obs, e); end
    end
    tick();
    checks++;
    if (pipes[55:48] !== 8'd0 || pipes[71:64] !== 8'd150) begin
      errors++; $display("FAIL small_row_recycle got min %0d pos %0d want 0,150", pipes[55:48], pipes[71:64]);
    end
  endtask

  initial begin
    test_reset();
    test_scroll();
    test_recycle();
    test_hit();
    test_speedup();
    test_enable_freeze();
    test_reset_on_recycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
